// File: rtl/utils_pkg.sv
// Shared AXI4 types for the pipeline bridge: channel payloads and flat port structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a (types and constants only).
package utils_pkg;

  localparam int AXI_PIPE_MAX_DEPTH = 16;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_USER_W = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } s_axi_aw_t;

  typedef s_axi_aw_t s_axi_ar_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } s_axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } s_axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } s_axi_r_t;

  // Field order matches the per-channel payload structs so the top can pack by concatenation.
  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic [AXI_USER_W-1:0] awuser;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic [AXI_USER_W-1:0] wuser;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic [AXI_USER_W-1:0] aruser;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic [AXI_USER_W-1:0] buser;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [AXI_USER_W-1:0] ruser;
    logic                  rvalid;
  } s_axi_miso_t;

  // Pointer width for a ring of 'depth' entries; never narrower than one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi_chan_fifo.sv
// Elastic buffer for one AXI channel: circular FIFO of DEPTH entries, or a wire when DEPTH==0.
// Latency: 1 cycle from accept to output when empty (no bypass); 0 cycles when DEPTH==0.
// Backpressure: in_ready depends only on stored count (full refuses push even with a same-cycle pop).
module axi_chan_fifo
  import utils_pkg::*;
#(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
      assign out_data  = in_data;

      // Clock and reset have no role in the wire-through form.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
    end else begin : g_fifo
      localparam int PW = fifo_ptr_w(DEPTH);
      localparam int CW = $clog2(DEPTH + 1);
      localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
      localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

      T              r_mem [DEPTH];
      logic [PW-1:0] r_wr_ptr;
      logic [PW-1:0] r_rd_ptr;
      logic [CW-1:0] r_count;
      logic          w_push;
      logic          w_pop;

      // Held low while in reset so nothing is accepted or presented.
      assign in_ready  = rst && (r_count != FULL_CNT);
      assign out_valid = rst && (r_count != '0);
      assign w_push    = in_valid && in_ready;
      assign w_pop     = out_valid && out_ready;
      assign out_data  = r_mem[r_rd_ptr];

      // Payload storage; deliberately not reset.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= in_data;
        end
      end

      // Ring pointers and occupancy; pointers wrap at DEPTH-1 so any depth works.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
          end
          if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
          end
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axi_pipe_bridge.sv
// AXI4 pipeline bridge: five independent channel buffers between s_mosi/s_miso and m_mosi/m_miso.
// Latency: 1 cycle per buffered channel, 0 for any channel with depth 0.
// Backpressure: per-channel registered ready; optional counters under AXI_PIPE_BRIDGE_STATS_EN.
module axi_pipe_bridge
  import utils_pkg::*;
#(
  parameter int AW_DEPTH = 2,
  parameter int W_DEPTH  = 2,
  parameter int B_DEPTH  = 2,
  parameter int AR_DEPTH = 2,
  parameter int R_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t s_mosi,
  output s_axi_miso_t s_miso,
  output s_axi_mosi_t m_mosi,
  input  s_axi_miso_t m_miso
`ifdef AXI_PIPE_BRIDGE_STATS_EN
  ,
  output logic [31:0] aw_cnt,
  output logic [31:0] ar_cnt,
  output logic [31:0] wbeat_cnt,
  output logic [31:0] rbeat_cnt,
  output logic [31:0] stall_cnt
`endif
);

  s_axi_aw_t w_aw_in, w_aw_out;
  s_axi_w_t  w_w_in,  w_w_out;
  s_axi_b_t  w_b_in,  w_b_out;
  s_axi_ar_t w_ar_in, w_ar_out;
  s_axi_r_t  w_r_in,  w_r_out;
  logic w_aw_rdy, w_aw_vld, w_w_rdy, w_w_vld, w_b_rdy, w_b_vld;
  logic w_ar_rdy, w_ar_vld, w_r_rdy, w_r_vld;

  assign w_aw_in = {s_mosi.awid, s_mosi.awaddr, s_mosi.awlen, s_mosi.awsize, s_mosi.awburst,
                    s_mosi.awlock, s_mosi.awcache, s_mosi.awprot, s_mosi.awqos,
                    s_mosi.awregion, s_mosi.awuser};
  assign w_w_in  = {s_mosi.wdata, s_mosi.wstrb, s_mosi.wlast, s_mosi.wuser};
  assign w_b_in  = {m_miso.bid, m_miso.bresp, m_miso.buser};
  assign w_ar_in = {s_mosi.arid, s_mosi.araddr, s_mosi.arlen, s_mosi.arsize, s_mosi.arburst,
                    s_mosi.arlock, s_mosi.arcache, s_mosi.arprot, s_mosi.arqos,
                    s_mosi.arregion, s_mosi.aruser};
  assign w_r_in  = {m_miso.rid, m_miso.rdata, m_miso.rresp, m_miso.rlast, m_miso.ruser};

  axi_chan_fifo #(.T(s_axi_aw_t), .DEPTH(AW_DEPTH)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(s_mosi.awvalid), .in_ready(w_aw_rdy), .in_data(w_aw_in),
    .out_valid(w_aw_vld), .out_ready(m_miso.awready), .out_data(w_aw_out)
  );

  axi_chan_fifo #(.T(s_axi_w_t), .DEPTH(W_DEPTH)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(s_mosi.wvalid), .in_ready(w_w_rdy), .in_data(w_w_in),
    .out_valid(w_w_vld), .out_ready(m_miso.wready), .out_data(w_w_out)
  );

  axi_chan_fifo #(.T(s_axi_b_t), .DEPTH(B_DEPTH)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(m_miso.bvalid), .in_ready(w_b_rdy), .in_data(w_b_in),
    .out_valid(w_b_vld), .out_ready(s_mosi.bready), .out_data(w_b_out)
  );

  axi_chan_fifo #(.T(s_axi_ar_t), .DEPTH(AR_DEPTH)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(s_mosi.arvalid), .in_ready(w_ar_rdy), .in_data(w_ar_in),
    .out_valid(w_ar_vld), .out_ready(m_miso.arready), .out_data(w_ar_out)
  );

  axi_chan_fifo #(.T(s_axi_r_t), .DEPTH(R_DEPTH)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(m_miso.rvalid), .in_ready(w_r_rdy), .in_data(w_r_in),
    .out_valid(w_r_vld), .out_ready(s_mosi.rready), .out_data(w_r_out)
  );

  // Port structs are laid out in channel-payload order, so concatenation packs them.
  assign m_mosi = {w_aw_out, w_aw_vld, w_w_out, w_w_vld, w_b_rdy, w_ar_out, w_ar_vld, w_r_rdy};
  assign s_miso = {w_aw_rdy, w_w_rdy, w_b_out, w_b_vld, w_ar_rdy, w_r_out, w_r_vld};

`ifdef AXI_PIPE_BRIDGE_STATS_EN
  logic [31:0] r_aw_cnt, r_ar_cnt, r_wbeat_cnt, r_rbeat_cnt, r_stall_cnt;
  logic        w_stall;

  assign w_stall = (w_aw_vld && !m_miso.awready) || (w_w_vld && !m_miso.wready) ||
                   (w_ar_vld && !m_miso.arready) || (m_miso.bvalid && !w_b_rdy) ||
                   (m_miso.rvalid && !w_r_rdy);

  // Downstream-side handshake and stall counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_aw_cnt    <= '0;
      r_ar_cnt    <= '0;
      r_wbeat_cnt <= '0;
      r_rbeat_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_aw_vld && m_miso.awready) r_aw_cnt    <= r_aw_cnt + 32'd1;
      if (w_ar_vld && m_miso.arready) r_ar_cnt    <= r_ar_cnt + 32'd1;
      if (w_w_vld && m_miso.wready)   r_wbeat_cnt <= r_wbeat_cnt + 32'd1;
      if (m_miso.rvalid && w_r_rdy)   r_rbeat_cnt <= r_rbeat_cnt + 32'd1;
      if (w_stall)                    r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign aw_cnt    = r_aw_cnt;
  assign ar_cnt    = r_ar_cnt;
  assign wbeat_cnt = r_wbeat_cnt;
  assign rbeat_cnt = r_rbeat_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/axi_pipe_bridge.md
Name: axi_pipe_bridge

Overview:
- Parametrised AXI4 pipeline bridge between a slave-side struct port (s_mosi/s_miso) and a master-side struct port (m_mosi/m_miso).
- Each of the five AXI channels (AW, W, B, AR, R) gets an independently sized elastic buffer.
- Used to break timing paths and decouple producer/consumer stalls between the DMA and its interconnect.
- A depth of 0 collapses a channel to a combinational wire-through.

Parameters:
- AW_DEPTH, 2, AW channel buffer entries (0 = passthrough, 1..16 legal)
- W_DEPTH, 2, W channel buffer entries (0..16)
- B_DEPTH, 2, B channel buffer entries (0..16)
- AR_DEPTH, 2, AR channel buffer entries (0..16)
- R_DEPTH, 2, R channel buffer entries (0..16)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- s_mosi  in  s_axi_mosi_t  requests from upstream master
- s_miso  out  s_axi_miso_t  responses to upstream master
- m_mosi  out  s_axi_mosi_t  requests to downstream slave
- m_miso  in  s_axi_miso_t  responses from downstream slave

Behaviour:
- Forward channels (AW, W, AR) run s_mosi -> m_mosi. Return channels (B, R) run m_miso -> s_miso.
- Per channel with DEPTH>0, circular FIFO of channel payload:
  - AW: id, addr, len, size, burst, lock, cache, prot, qos, region, user.
  - W: data, strb, last, user.
  - B: id, resp, user.
  - AR: same fields as AW.
  - R: id, data, resp, last, user.
- Push when in_valid && in_ready. in_ready = (count != DEPTH).
- Pop when out_valid && out_ready. out_valid = (count != 0).
- Output payload = head entry, held stable while out_valid && !out_ready.
- Ready is registered-state only: no combinational path from out_ready to in_ready. A full FIFO refuses a push even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty FIFO: the push is accepted, and the pop cannot happen because out_valid is 0.
- Pointers are $clog2(DEPTH)-bit (min 1), wrap to 0 after DEPTH-1. DEPTH need not be a power of 2. Count is $clog2(DEPTH+1) bits.
- Latency: a beat accepted at edge N appears at the output after edge N (1 cycle) when the FIFO was empty. There is no bypass.
- DEPTH==0: out payload/valid = in payload/valid, in_ready = out_ready, with zero latency.
- Throughput: DEPTH>=2 sustains 1 beat/cycle. DEPTH==1 sustains 1 beat per 2 cycles.
- Reset (rst==0 at edge):
  - Pointers and counts clear. Stored payload is not cleared.
  - While rst==0, all out_valid=0 and all in_ready=0.
  - First cycle after release: all in_ready=1 (DEPTH>0), all valid=0.
  - Mid-transfer reset drops all buffered beats; no partial bursts are flushed.
- The bridge is transaction-agnostic: no reordering, no ID inspection, no burst splitting, no last-beat generation. The wlast/rlast bits are passed through unmodified.

Optional Feature:
- Macro AXI_PIPE_BRIDGE_STATS_EN adds output ports:
  - aw_cnt (32), ar_cnt (32): counts of address handshakes at m_mosi.
  - wbeat_cnt (32), rbeat_cnt (32): counts of data beats at the downstream side.
  - stall_cnt (32): cycles where any m-side valid=1 and ready=0.
- Counters are cleared by rst, wrap modulo 2^32, and increment once per handshake cycle.
- Without the macro, these ports and their logic are absent. Channel behaviour is identical either way.

Decomposition:
- utils_pkg gains:
  - per-channel payload structs s_axi_aw_t, s_axi_w_t, s_axi_b_t, s_axi_ar_t, s_axi_r_t.
  - constant AXI_PIPE_MAX_DEPTH=16.
- One sub-module, axi_chan_fifo: parameters type T and DEPTH. Ports clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data. It includes the DEPTH==0 generate branch.
- axi_pipe_bridge instantiates axi_chan_fifo five times, plus struct pack/unpack and the optional counters.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1. Expect m_mosi.awvalid=wvalid=arvalid=0 and s_miso.bvalid=rvalid=0 during and after. Expect all readies 0 during reset and 1 on the cycle after release.
- Single write, defaults: AW addr=0x1000, len=3, then 4 W beats data=0xA0..0xA3 with wlast on the 4th, m ready=1. Expect each beat on m_mosi 1 cycle after acceptance, order and wlast preserved, then B resp=OKAY id=2 returned on s_miso 1 cycle after m_miso.bvalid.
- Backpressure/full: W_DEPTH=2, m_wready=0, push 3 beats. Expect s_miso.wready=0 after 2 accepts, 3rd beat held. Raise m_wready: expect beats 0,1,2 in order and no loss or duplication.
- Streaming throughput: R_DEPTH=2, 64-beat read burst with s rready=1 and m rvalid=1 continuously. Expect 64 consecutive rvalid cycles at s_miso after 1-cycle latency, with rlast only on beat 63.
- Passthrough: AR_DEPTH=0, drive s arvalid=1, araddr=0x2000. Expect m_mosi.arvalid=1 and araddr=0x2000 the same cycle, and s_miso.arready to mirror m_miso.arready combinationally.
- Reset mid-burst: AW accepted and 2 of 4 W beats buffered with m_wready=0, then assert rst for 1 cycle. Expect m_mosi.wvalid=0 after reset and the FIFO empty. With STATS_EN, expect all counters read 0.
